// File: rtl/motor_scheduler.sv
// motor_scheduler: arbitrates the shared fan/turntable motor between the microwave
// and the air handler. It soft-ramps the duty command one step per tick wrap and
// holds a danger lockout until the hazard has stayed clear for a cooldown period.
module motor_scheduler #(
   parameter int unsigned RAMP_DIV    = 10,
   parameter int unsigned COOL_CYCLES = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       oven_req,
   input  logic [3:0] oven_duty,
   input  logic       air_req,
   input  logic [3:0] air_duty,
   input  logic       danger_flag,
   output logic [3:0] duty_out,
   output logic       motor_en,
   output logic       grant_oven,
   output logic       grant_air,
   output logic       lockout
);

   localparam int unsigned DUTY_W = 4;
   localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned COOL_W = $clog2(COOL_CYCLES + 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(9);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SLEW,
      S_RUN,
      S_RAMP_DOWN,
      S_LOCKOUT
   } state_t;

   state_t state, state_nxt;

   logic [TICK_W-1:0] tick_q, tick_nxt;
   logic [COOL_W-1:0] cool_q, cool_nxt;
   logic [DUTY_W-1:0] duty_nxt;
   logic              motor_en_nxt, grant_oven_nxt, grant_air_nxt, lockout_nxt;

   logic [DUTY_W-1:0] oven_clamped_c, air_clamped_c, target_c;
   logic              owner_req_c, release_c, tick_wrap_c;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
      return (d > DUTY_MAX) ? DUTY_MAX : d;
   endfunction

   // Target follows the current owner's clamped request; release on drop or oven preempting air
   assign oven_clamped_c = clamp_duty(oven_duty);
   assign air_clamped_c  = clamp_duty(air_duty);
   assign target_c       = grant_oven ? oven_clamped_c : (grant_air ? air_clamped_c : '0);
   assign owner_req_c    = grant_oven ? oven_req : air_req;
   assign release_c      = !owner_req_c || (grant_air && oven_req);
   assign tick_wrap_c    = (tick_q == TICK_W'(RAMP_DIV - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; danger overrides every state
   always_comb begin
      state_nxt = state;
      if (danger_flag) begin
         state_nxt = S_LOCKOUT;
      end else begin
         case (state)
            S_IDLE:      if (oven_req || air_req) state_nxt = S_SLEW;
            S_SLEW:      if (release_c)                state_nxt = S_RAMP_DOWN;
                         else if (duty_out == target_c) state_nxt = S_RUN;
            S_RUN:       if (release_c)                state_nxt = S_RAMP_DOWN;
                         else if (duty_out != target_c) state_nxt = S_SLEW;
            S_RAMP_DOWN: if (duty_out == '0)           state_nxt = S_IDLE;
            S_LOCKOUT:   if (cool_q == COOL_W'(1))     state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs and the tick/cool counters
   always_comb begin
      duty_nxt       = duty_out;
      motor_en_nxt   = motor_en;
      grant_oven_nxt = grant_oven;
      grant_air_nxt  = grant_air;
      lockout_nxt    = 1'b0;
      tick_nxt       = tick_q;
      cool_nxt       = cool_q;
      if (danger_flag) begin
         duty_nxt       = '0;
         motor_en_nxt   = 1'b0;
         grant_oven_nxt = 1'b0;
         grant_air_nxt  = 1'b0;
         lockout_nxt    = 1'b1;
         cool_nxt       = COOL_W'(COOL_CYCLES);
      end else begin
         case (state)
            S_IDLE: begin
               duty_nxt       = '0;
               motor_en_nxt   = oven_req || air_req;
               grant_oven_nxt = oven_req;
               grant_air_nxt  = !oven_req && air_req;
               tick_nxt       = '0;
            end
            S_SLEW: begin
               if (release_c) begin
                  tick_nxt = '0;
               end else if (duty_out != target_c) begin
                  if (tick_wrap_c) begin
                     tick_nxt = '0;
                     duty_nxt = (target_c > duty_out) ? duty_out + DUTY_W'(1)
                                                      : duty_out - DUTY_W'(1);
                  end else begin
                     tick_nxt = tick_q + TICK_W'(1);
                  end
               end
            end
            S_RUN: begin
               if (release_c || duty_out != target_c) tick_nxt = '0;
            end
            S_RAMP_DOWN: begin
               if (duty_out == '0) begin
                  motor_en_nxt   = 1'b0;
                  grant_oven_nxt = 1'b0;
                  grant_air_nxt  = 1'b0;
               end else if (tick_wrap_c) begin
                  tick_nxt = '0;
                  duty_nxt = duty_out - DUTY_W'(1);
               end else begin
                  tick_nxt = tick_q + TICK_W'(1);
               end
            end
            S_LOCKOUT: begin
               duty_nxt       = '0;
               motor_en_nxt   = 1'b0;
               grant_oven_nxt = 1'b0;
               grant_air_nxt  = 1'b0;
               lockout_nxt    = (cool_q != COOL_W'(1));
               cool_nxt       = cool_q - COOL_W'(1);
            end
            default: begin
               duty_nxt       = '0;
               motor_en_nxt   = 1'b0;
               grant_oven_nxt = 1'b0;
               grant_air_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Output and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_out   <= '0;
         motor_en   <= 1'b0;
         grant_oven <= 1'b0;
         grant_air  <= 1'b0;
         lockout    <= 1'b0;
         tick_q     <= '0;
         cool_q     <= '0;
      end else begin
         duty_out   <= duty_nxt;
         motor_en   <= motor_en_nxt;
         grant_oven <= grant_oven_nxt;
         grant_air  <= grant_air_nxt;
         lockout    <= lockout_nxt;
         tick_q     <= tick_nxt;
         cool_q     <= cool_nxt;
      end
   end

endmodule

// File: tb/tb_motor_scheduler.sv
// tb_motor_scheduler: directed timing scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the motor arbitration rules.
`timescale 1ns/1ps
module tb_motor_scheduler;

   localparam int RD   = 10;
   localparam int COOL = 100;

   logic       clk = 1'b0;
   logic       reset;
   logic       oven_req, air_req, danger_flag;
   logic [3:0] oven_duty, air_duty;
   logic [3:0] duty_out;
   logic       motor_en, grant_oven, grant_air, lockout;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: owner 0=none 1=oven 2=air; m_lock = lockout cycles remaining
   int m_owner, m_duty, m_cnt, m_lock;
   bit m_en, m_drain, m_settled;

   motor_scheduler #(.RAMP_DIV(RD), .COOL_CYCLES(COOL)) dut (
      .clk(clk), .reset(reset),
      .oven_req(oven_req), .oven_duty(oven_duty),
      .air_req(air_req), .air_duty(air_duty),
      .danger_flag(danger_flag),
      .duty_out(duty_out), .motor_en(motor_en),
      .grant_oven(grant_oven), .grant_air(grant_air), .lockout(lockout)
   );

   always #5 clk = ~clk;

   function automatic int clampd(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   function automatic logic [7:0] pack(input bit l, input bit ga, input bit go, input bit en, input int d);
      return {l, ga, go, en, 4'(d)};
   endfunction

   function automatic logic [7:0] outs();
      return {lockout, grant_air, grant_oven, motor_en, duty_out};
   endfunction

   function automatic logic [7:0] model_outs();
      return pack(m_lock > 0, m_owner == 2, m_owner == 1, m_en, m_duty);
   endfunction

   function automatic void model_reset();
      m_owner = 0; m_duty = 0; m_cnt = 0; m_lock = 0;
      m_en = 0; m_drain = 0; m_settled = 0;
   endfunction

   function automatic void model_step();
      int tgt;
      if (danger_flag) begin
         m_lock = COOL; m_owner = 0; m_duty = 0; m_en = 0; m_drain = 0; m_settled = 0;
      end else if (m_lock > 0) begin
         m_lock--;
      end else if (m_owner == 0) begin
         if (oven_req) m_owner = 1;
         else if (air_req) m_owner = 2;
         if (m_owner != 0) begin
            m_en = 1; m_cnt = 0; m_settled = 0; m_drain = 0;
         end
      end else if (m_drain) begin
         if (m_duty == 0) begin
            m_owner = 0; m_en = 0; m_drain = 0;
         end else begin
            m_cnt++;
            if (m_cnt == RD) begin m_cnt = 0; m_duty--; end
         end
      end else if ((m_owner == 1 && !oven_req) || (m_owner == 2 && (!air_req || oven_req))) begin
         m_drain = 1; m_cnt = 0; m_settled = 0;
      end else begin
         tgt = (m_owner == 1) ? clampd(int'(oven_duty)) : clampd(int'(air_duty));
         if (m_settled) begin
            if (tgt != m_duty) begin m_settled = 0; m_cnt = 0; end
         end else if (tgt == m_duty) begin
            m_settled = 1;
         end else begin
            m_cnt++;
            if (m_cnt == RD) begin
               m_cnt = 0;
               m_duty += (tgt > m_duty) ? 1 : -1;
            end
         end
      end
   endfunction

   // One clock: model follows the edge, outputs sampled 1ns later
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; oven_req = 0; air_req = 0; danger_flag = 0; oven_duty = 0; air_duty = 0;
      model_reset();
      #3;
      checks++;
      if (outs() !== pack(0, 0, 0, 0, 0)) begin
         failures++; $display("FAIL reset_async got=%h exp=%h", outs(), pack(0, 0, 0, 0, 0));
      end
      tick(); tick();
      checks++;
      if (outs() !== pack(0, 0, 0, 0, 0)) begin
         failures++; $display("FAIL reset_hold got=%h exp=%h", outs(), pack(0, 0, 0, 0, 0));
      end
      reset = 1'b0;
      tick();
      checks++;
      if (outs() !== pack(0, 0, 0, 0, 0)) begin
         failures++; $display("FAIL idle_after_reset got=%h exp=%h", outs(), pack(0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_basic_ramp();
      air_duty = 4'd5; air_req = 1'b1;
      tick();
      checks++;
      if (outs() !== pack(0, 1, 0, 1, 0)) begin
         failures++; $display("FAIL basic_grant got=%h exp=%h", outs(), pack(0, 1, 0, 1, 0));
      end
      for (int k = 1; k <= 60; k++) begin
         tick();
         checks++;
         if (outs() !== pack(0, 1, 0, 1, (k / RD > 5) ? 5 : k / RD)) begin
            failures++;
            $display("FAIL basic_ramp k=%0d got=%h exp=%h", k, outs(), pack(0, 1, 0, 1, (k / RD > 5) ? 5 : k / RD));
         end
      end
   endtask

   task automatic test_preemption();
      logic [7:0] exp;
      int n;
      oven_duty = 4'd3; oven_req = 1'b1;
      for (int k = 1; k <= 90; k++) begin
         tick();
         if (k <= 51)      exp = pack(0, 1, 0, 1, 5 - (k - 1) / RD);
         else if (k == 52) exp = pack(0, 0, 0, 0, 0);
         else              exp = pack(0, 0, 1, 1, ((k - 53) / RD > 3) ? 3 : (k - 53) / RD);
         checks++;
         if (outs() !== exp) begin
            failures++; $display("FAIL preempt k=%0d got=%h exp=%h", k, outs(), exp);
         end
      end
      oven_req = 1'b0; air_req = 1'b0;
      n = 0;
      while (motor_en !== 1'b0 && n < 200) begin tick(); n++; end
      checks++;
      if (n != 32) begin
         failures++; $display("FAIL preempt_release cycles got=%0d exp=32", n);
      end
   endtask

   task automatic test_simultaneous_clamp();
      int n;
      oven_duty = 4'd12; air_duty = 4'($urandom_range(0, 15));
      oven_req = 1'b1; air_req = 1'b1;
      tick();
      checks++;
      if (outs() !== pack(0, 0, 1, 1, 0)) begin
         failures++; $display("FAIL simul_grant got=%h exp=%h", outs(), pack(0, 0, 1, 1, 0));
      end
      for (int k = 1; k <= 95; k++) begin
         tick();
         checks++;
         if (outs() !== pack(0, 0, 1, 1, (k / RD > 9) ? 9 : k / RD)) begin
            failures++;
            $display("FAIL clamp_ramp k=%0d got=%h exp=%h", k, outs(), pack(0, 0, 1, 1, (k / RD > 9) ? 9 : k / RD));
         end
      end
      oven_req = 1'b0; air_req = 1'b0;
      n = 0;
      while (motor_en !== 1'b0 && n < 300) begin tick(); n++; end
      checks++;
      if (n != 92) begin
         failures++; $display("FAIL clamp_release cycles got=%0d exp=92", n);
      end
   endtask

   task automatic test_danger_mid_slew();
      int n;
      oven_duty = 4'd9; oven_req = 1'b1;
      tick();
      repeat (40) tick();
      checks++;
      if (outs() !== pack(0, 0, 1, 1, 4)) begin
         failures++; $display("FAIL danger_pre got=%h exp=%h", outs(), pack(0, 0, 1, 1, 4));
      end
      danger_flag = 1'b1;
      tick();
      danger_flag = 1'b0;
      checks++;
      if (outs() !== pack(1, 0, 0, 0, 0)) begin
         failures++; $display("FAIL danger_stop got=%h exp=%h", outs(), pack(1, 0, 0, 0, 0));
      end
      for (int k = 1; k <= 100; k++) begin
         tick();
         checks++;
         if (outs() !== pack(k < COOL, 0, 0, 0, 0)) begin
            failures++; $display("FAIL lockout_hold k=%0d got=%h exp=%h", k, outs(), pack(k < COOL, 0, 0, 0, 0));
         end
      end
      tick();
      checks++;
      if (outs() !== pack(0, 0, 1, 1, 0)) begin
         failures++; $display("FAIL danger_regrant got=%h exp=%h", outs(), pack(0, 0, 1, 1, 0));
      end
      oven_req = 1'b0;
      n = 0;
      while (motor_en !== 1'b0 && n < 20) begin tick(); n++; end
      checks++;
      if (motor_en !== 1'b0) begin
         failures++; $display("FAIL danger_release_timeout got=%b exp=0", motor_en);
      end
   endtask

   task automatic test_lockout_restart();
      danger_flag = 1'b1;
      tick();
      danger_flag = 1'b0;
      repeat (60) tick();
      checks++;
      if (outs() !== pack(1, 0, 0, 0, 0)) begin
         failures++; $display("FAIL restart_mid got=%h exp=%h", outs(), pack(1, 0, 0, 0, 0));
      end
      danger_flag = 1'b1;
      tick();
      danger_flag = 1'b0;
      for (int k = 1; k <= 101; k++) begin
         tick();
         checks++;
         if (lockout !== (k < COOL)) begin
            failures++; $display("FAIL restart_hold k=%0d got=%b exp=%b", k, lockout, (k < COOL));
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      air_duty = 4'd7; air_req = 1'b1; oven_req = 1'b0;
      tick();
      repeat (75) tick();
      checks++;
      if (outs() !== pack(0, 1, 0, 1, 7)) begin
         failures++; $display("FAIL pre_reset_run got=%h exp=%h", outs(), pack(0, 1, 0, 1, 7));
      end
      #2 reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (outs() !== pack(0, 0, 0, 0, 0)) begin
         failures++; $display("FAIL reset_async_mid got=%h exp=%h", outs(), pack(0, 0, 0, 0, 0));
      end
      #3 reset = 1'b0;
      tick();
      checks++;
      if (outs() !== pack(0, 1, 0, 1, 0)) begin
         failures++; $display("FAIL reset_regrant got=%h exp=%h", outs(), pack(0, 1, 0, 1, 0));
      end
      air_req = 1'b0;
      n = 0;
      while (motor_en !== 1'b0 && n < 20) begin tick(); n++; end
      checks++;
      if (motor_en !== 1'b0) begin
         failures++; $display("FAIL reset_release_timeout got=%b exp=0", motor_en);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) oven_req = ~oven_req;
         if ($urandom_range(0, 24) == 0) air_req = ~air_req;
         if ($urandom_range(0, 19) == 0) oven_duty = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) air_duty = 4'($urandom_range(0, 15));
         danger_flag = ($urandom_range(0, 299) == 0);
         tick();
         checks++;
         if (outs() !== model_outs()) begin
            failures++; $display("FAIL random c=%0d got=%h exp=%h", c, outs(), model_outs());
         end
         checks++;
         if ((grant_oven && grant_air) || (!motor_en && duty_out != 4'd0)) begin
            failures++;
            $display("FAIL random_invariant c=%0d go=%b ga=%b en=%b duty=%0d exp_exclusive_and_zero_duty_when_off",
                     c, grant_oven, grant_air, motor_en, duty_out);
         end
      end
      danger_flag = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_ramp();
      test_preemption();
      test_simultaneous_clamp();
      test_danger_mid_slew();
      test_lockout_restart();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
